// File: rtl/shifter_arbiter_if.sv
// shifter_arbiter_if
//   Bundles the two request channels, the shifter datapath link, the tagged
//   result channel and the status outputs of shifter_arbiter.
//   slave  : seen by the arbiter (requests/RES_READY/SH_D_OUT in, the rest out)
//   master : seen by the surrounding logic (the mirror image)
interface shifter_arbiter_if #(
    parameter int CNT_W = 16
);
    // Requester 0
    logic        REQ0_VALID;
    logic        REQ0_DIR;
    logic [4:0]  REQ0_AMT;
    logic [31:0] REQ0_DATA;
    logic        REQ0_READY;
    // Requester 1
    logic        REQ1_VALID;
    logic        REQ1_DIR;
    logic [4:0]  REQ1_AMT;
    logic [31:0] REQ1_DATA;
    logic        REQ1_READY;
    // Shifter datapath
    logic        SH_DIR;
    logic [4:0]  SH_AMT;
    logic [31:0] SH_D_IN;
    logic [31:0] SH_D_OUT;
    // Result channel
    logic        RES_VALID;
    logic        RES_ID;
    logic [31:0] RES_DATA;
    logic        RES_READY;
    // Status
    logic             BUSY;
    logic [CNT_W-1:0] OP_CNT;

    modport slave (
        input  REQ0_VALID, REQ0_DIR, REQ0_AMT, REQ0_DATA,
        input  REQ1_VALID, REQ1_DIR, REQ1_AMT, REQ1_DATA,
        output REQ0_READY, REQ1_READY,
        output SH_DIR, SH_AMT, SH_D_IN,
        input  SH_D_OUT,
        output RES_VALID, RES_ID, RES_DATA,
        input  RES_READY,
        output BUSY, OP_CNT
    );

    modport master (
        output REQ0_VALID, REQ0_DIR, REQ0_AMT, REQ0_DATA,
        output REQ1_VALID, REQ1_DIR, REQ1_AMT, REQ1_DATA,
        input  REQ0_READY, REQ1_READY,
        input  SH_DIR, SH_AMT, SH_D_IN,
        output SH_D_OUT,
        input  RES_VALID, RES_ID, RES_DATA,
        output RES_READY,
        input  BUSY, OP_CNT
    );
endinterface

// File: rtl/shifter_arbiter.sv
// shifter_arbiter
//   Shares one external combinational 32-bit barrel shifter between two
//   requesters with round-robin priority. A granted operation is latched into
//   operand registers that drive the shifter, the result is registered one
//   cycle later and offered on a valid/ready channel tagged with the owner ID.
// Ports
//   CLK   : clock, all state changes on the rising edge
//   RST_N : synchronous active-low reset
//   bus   : shifter_arbiter_if.slave (requests, shifter link, result, status)
module shifter_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic               CLK,
    input  logic               RST_N,
    shifter_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             dir_q, dir_d;
    logic [4:0]       amt_q, amt_d;
    logic [31:0]      data_q, data_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic             res_valid_q, res_valid_d;
    logic             res_id_q, res_id_d;
    logic [31:0]      res_data_q, res_data_d;
    logic [CNT_W-1:0] op_cnt_q, op_cnt_d;

    logic gnt_vld;
    logic gnt_id;

    // Grant only in IDLE. On a tie the requester that did not win last time
    // goes first; otherwise whichever one is asking.
    always_comb begin
        gnt_vld = (state_q == IDLE) && (bus.REQ0_VALID || bus.REQ1_VALID);
        if (bus.REQ0_VALID && bus.REQ1_VALID) gnt_id = ~last_q;
        else                                  gnt_id = bus.REQ1_VALID;
    end

    assign bus.REQ0_READY = gnt_vld && !gnt_id;
    assign bus.REQ1_READY = gnt_vld &&  gnt_id;

    // The shifter sees the operand registers directly, so its inputs are
    // stable for the whole EXEC cycle.
    assign bus.SH_DIR    = dir_q;
    assign bus.SH_AMT    = amt_q;
    assign bus.SH_D_IN   = data_q;

    assign bus.RES_VALID = res_valid_q;
    assign bus.RES_ID    = res_id_q;
    assign bus.RES_DATA  = res_data_q;
    assign bus.BUSY      = (state_q != IDLE);
    assign bus.OP_CNT    = op_cnt_q;

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        amt_d       = amt_q;
        data_d      = data_q;
        owner_d     = owner_q;
        last_d      = last_q;
        res_valid_d = res_valid_q;
        res_id_d    = res_id_q;
        res_data_d  = res_data_q;
        op_cnt_d    = op_cnt_q;

        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    dir_d   = gnt_id ? bus.REQ1_DIR  : bus.REQ0_DIR;
                    amt_d   = gnt_id ? bus.REQ1_AMT  : bus.REQ0_AMT;
                    data_d  = gnt_id ? bus.REQ1_DATA : bus.REQ0_DATA;
                    owner_d = gnt_id;
                    last_d  = gnt_id;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                res_data_d  = bus.SH_D_OUT;
                res_id_d    = owner_q;
                res_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                // Return to IDLE on the handshake; the next grant is made
                // from IDLE, never in the handshake cycle itself.
                if (bus.RES_READY) begin
                    res_valid_d = 1'b0;
                    op_cnt_d    = op_cnt_q + 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            dir_q       <= 1'b0;
            amt_q       <= '0;
            data_q      <= '0;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;  // REQ0 wins the first tie
            res_valid_q <= 1'b0;
            res_id_q    <= 1'b0;
            res_data_q  <= '0;
            op_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            amt_q       <= amt_d;
            data_q      <= data_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_data_q  <= res_data_d;
            op_cnt_q    <= op_cnt_d;
        end
    end

endmodule

// File: tb/tb_shifter_arbiter.sv
module tb_shifter_arbiter;
    localparam int CNT_W = 2;

    logic CLK = 1'b0;
    logic RST_N;
    always #5 CLK = ~CLK;

    shifter_arbiter_if #(.CNT_W(CNT_W)) bus();
    shifter_arbiter #(.CNT_W(CNT_W)) dut (.CLK(CLK), .RST_N(RST_N), .bus(bus));

    // External combinational barrel shifter
    assign bus.SH_D_OUT = bus.SH_DIR ? 32'($signed(bus.SH_D_IN) >>> bus.SH_AMT)
                                     : (bus.SH_D_IN << bus.SH_AMT);

    int   nvec = 0;
    int   nerr = 0;
    logic exp_last;
    int   exp_cnt;

    // Reference: left = multiply by 2^amt mod 2^32, right = floor(signed / 2^amt)
    function automatic logic [31:0] ref_shift(input logic dir, input logic [4:0] amt,
                                              input logic [31:0] d);
        longint s, dv, q;
        logic [63:0] p;
        if (!dir) begin
            p = {32'd0, d} * (64'd1 << amt);
            return p[31:0];
        end
        s  = longint'($signed(d));
        dv = longint'(64'd1 << amt);
        q  = s / dv;
        if (s < 0 && (s % dv) != 0) q = q - 1;
        return 32'(q);
    endfunction

    task automatic set_req(input bit id, input bit v, input bit dir,
                           input logic [4:0] amt, input logic [31:0] data);
        if (!id) begin
            bus.REQ0_VALID = v; bus.REQ0_DIR = dir; bus.REQ0_AMT = amt; bus.REQ0_DATA = data;
        end else begin
            bus.REQ1_VALID = v; bus.REQ1_DIR = dir; bus.REQ1_AMT = amt; bus.REQ1_DATA = data;
        end
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);
        bus.RES_READY = 1'b0;
        @(negedge CLK);
        exp_last = 1'b1;
        exp_cnt  = 0;
    endtask

    task automatic test_reset();
        do_reset();
        nvec++; if (bus.RES_VALID !== 1'b0) begin nerr++; $display("FAIL reset_res_valid got %0h want 0", bus.RES_VALID); end
        nvec++; if (bus.RES_ID !== 1'b0) begin nerr++; $display("FAIL reset_res_id got %0h want 0", bus.RES_ID); end
        nvec++; if (bus.RES_DATA !== 32'h0) begin nerr++; $display("FAIL reset_res_data got %0h want 0", bus.RES_DATA); end
        nvec++; if (bus.OP_CNT !== 2'd0) begin nerr++; $display("FAIL reset_op_cnt got %0d want 0", bus.OP_CNT); end
        nvec++; if ({bus.SH_DIR, bus.SH_AMT, bus.SH_D_IN} !== 38'h0) begin nerr++; $display("FAIL reset_sh got %0h/%0h/%0h want 0", bus.SH_DIR, bus.SH_AMT, bus.SH_D_IN); end
        nvec++; if (bus.BUSY !== 1'b0) begin nerr++; $display("FAIL reset_busy got %0h want 0", bus.BUSY); end
        RST_N = 1'b1;
    endtask

    task automatic test_single();
        bus.RES_READY = 1'b1;
        set_req(0, 1, 0, 5'd4, 32'h1);
        #1;
        nvec++; if (bus.REQ0_READY !== 1'b1 || bus.REQ1_READY !== 1'b0) begin nerr++; $display("FAIL single_ready got %0h%0h want 10", bus.REQ0_READY, bus.REQ1_READY); end
        @(negedge CLK);
        nvec++; if (bus.REQ0_READY !== 1'b0) begin nerr++; $display("FAIL single_ready_exec got %0h want 0", bus.REQ0_READY); end
        nvec++; if (bus.BUSY !== 1'b1 || bus.RES_VALID !== 1'b0) begin nerr++; $display("FAIL single_exec busy/valid got %0h/%0h want 1/0", bus.BUSY, bus.RES_VALID); end
        nvec++; if (bus.SH_DIR !== 1'b0 || bus.SH_AMT !== 5'd4 || bus.SH_D_IN !== 32'h1) begin nerr++; $display("FAIL single_sh got %0h/%0h/%0h want 0/4/1", bus.SH_DIR, bus.SH_AMT, bus.SH_D_IN); end
        set_req(0, 0, 0, 0, 0);
        @(negedge CLK);
        nvec++; if (bus.RES_VALID !== 1'b1 || bus.RES_DATA !== 32'h10 || bus.RES_ID !== 1'b0) begin nerr++; $display("FAIL single_res got v%0h %0h id%0h want v1 10 id0", bus.RES_VALID, bus.RES_DATA, bus.RES_ID); end
        @(negedge CLK);
        exp_cnt = (exp_cnt + 1) % 4; exp_last = 1'b0;
        nvec++; if (bus.RES_VALID !== 1'b0 || bus.BUSY !== 1'b0) begin nerr++; $display("FAIL single_after got v%0h busy%0h want 0/0", bus.RES_VALID, bus.BUSY); end
        nvec++; if (bus.OP_CNT !== 2'(exp_cnt)) begin nerr++; $display("FAIL single_op_cnt got %0d want %0d", bus.OP_CNT, exp_cnt); end
    endtask

    task automatic test_asr();
        logic [4:0]  amts [2] = '{5'd4, 5'd31};
        logic [31:0] dats [2] = '{32'h8000_0000, 32'h7FFF_FFFF};
        logic [31:0] exps [2] = '{32'hF800_0000, 32'h0000_0000};
        bus.RES_READY = 1'b1;
        for (int k = 0; k < 2; k++) begin
            set_req(1, 1, 1, amts[k], dats[k]);
            #1;
            nvec++; if (bus.REQ1_READY !== 1'b1 || bus.REQ0_READY !== 1'b0) begin nerr++; $display("FAIL asr%0d_ready got %0h%0h want 01", k, bus.REQ0_READY, bus.REQ1_READY); end
            @(negedge CLK);
            set_req(1, 0, 0, 0, 0);
            @(negedge CLK);
            nvec++; if (bus.RES_VALID !== 1'b1 || bus.RES_DATA !== exps[k] || bus.RES_ID !== 1'b1) begin nerr++; $display("FAIL asr%0d_res got v%0h %0h id%0h want v1 %0h id1", k, bus.RES_VALID, bus.RES_DATA, bus.RES_ID, exps[k]); end
            @(negedge CLK);
            exp_cnt = (exp_cnt + 1) % 4; exp_last = 1'b1;
        end
    endtask

    task automatic test_round_robin();
        logic [31:0] d0, d1;
        logic [4:0]  a0, a1;
        logic        r0, r1;
        logic [31:0] want;
        do_reset();
        RST_N = 1'b1;
        bus.RES_READY = 1'b1;
        d0 = $urandom; d1 = $urandom; a0 = 5'($urandom); a1 = 5'($urandom);
        r0 = 1'($urandom); r1 = 1'($urandom);
        set_req(0, 1, r0, a0, d0);
        set_req(1, 1, r1, a1, d1);
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge CLK);
            #1;
            nvec++; if (bus.REQ0_READY !== (c % 6 == 0) || bus.REQ1_READY !== (c % 6 == 3)) begin nerr++; $display("FAIL rr_ready c%0d got %0h%0h", c, bus.REQ0_READY, bus.REQ1_READY); end
            if (c % 3 == 2) begin
                want = ((c / 3) % 2 == 0) ? ref_shift(r0, a0, d0) : ref_shift(r1, a1, d1);
                nvec++; if (bus.RES_VALID !== 1'b1 || bus.RES_ID !== 1'((c / 3) % 2) || bus.RES_DATA !== want) begin nerr++; $display("FAIL rr_res c%0d got v%0h id%0h %0h want v1 id%0d %0h", c, bus.RES_VALID, bus.RES_ID, bus.RES_DATA, (c / 3) % 2, want); end
            end
        end
        @(negedge CLK);
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);
        exp_cnt = 0; exp_last = 1'b1;
        nvec++; if (bus.OP_CNT !== 2'(exp_cnt) || bus.BUSY !== 1'b0) begin nerr++; $display("FAIL rr_end got cnt%0d busy%0h want %0d/0", bus.OP_CNT, bus.BUSY, exp_cnt); end
    endtask

    task automatic test_backpressure();
        bus.RES_READY = 1'b0;
        set_req(0, 1, 0, 5'd8, 32'h1234_5678);
        @(negedge CLK);
        set_req(0, 0, 0, 0, 0);
        set_req(1, 1, 0, 5'd1, 32'hFFFF_FFFF);  // must not be granted while busy
        @(negedge CLK);
        for (int c = 0; c < 10; c++) begin
            #1;
            nvec++; if (bus.RES_VALID !== 1'b1 || bus.RES_DATA !== 32'h3456_7800 || bus.RES_ID !== 1'b0) begin nerr++; $display("FAIL bp_hold c%0d got v%0h %0h id%0h want v1 34567800 id0", c, bus.RES_VALID, bus.RES_DATA, bus.RES_ID); end
            nvec++; if (bus.REQ0_READY !== 1'b0 || bus.REQ1_READY !== 1'b0 || bus.BUSY !== 1'b1) begin nerr++; $display("FAIL bp_ready c%0d got %0h%0h busy%0h want 00 busy1", c, bus.REQ0_READY, bus.REQ1_READY, bus.BUSY); end
            @(negedge CLK);
        end
        set_req(1, 0, 0, 0, 0);
        bus.RES_READY = 1'b1;
        @(negedge CLK);
        bus.RES_READY = 1'b0;
        exp_cnt = (exp_cnt + 1) % 4; exp_last = 1'b0;
        nvec++; if (bus.RES_VALID !== 1'b0 || bus.BUSY !== 1'b0 || bus.OP_CNT !== 2'(exp_cnt)) begin nerr++; $display("FAIL bp_release got v%0h busy%0h cnt%0d want 0/0/%0d", bus.RES_VALID, bus.BUSY, bus.OP_CNT, exp_cnt); end
        @(negedge CLK);
        nvec++; if (bus.RES_VALID !== 1'b0 || bus.BUSY !== 1'b0 || bus.OP_CNT !== 2'(exp_cnt)) begin nerr++; $display("FAIL bp_idle got v%0h busy%0h cnt%0d want 0/0/%0d", bus.RES_VALID, bus.BUSY, bus.OP_CNT, exp_cnt); end
    endtask

    task automatic test_reset_mid();
        bus.RES_READY = 1'b1;
        set_req(1, 1, 1, 5'd5, 32'hDEAD_BEEF);
        @(negedge CLK);
        set_req(1, 0, 0, 0, 0);
        RST_N = 1'b0;
        @(negedge CLK);
        exp_cnt = 0; exp_last = 1'b1;
        nvec++; if (bus.RES_VALID !== 1'b0 || bus.RES_DATA !== 32'h0 || bus.OP_CNT !== 2'd0 || bus.BUSY !== 1'b0) begin nerr++; $display("FAIL midrst_res got v%0h %0h cnt%0d busy%0h want all 0", bus.RES_VALID, bus.RES_DATA, bus.OP_CNT, bus.BUSY); end
        nvec++; if ({bus.SH_DIR, bus.SH_AMT, bus.SH_D_IN} !== 38'h0) begin nerr++; $display("FAIL midrst_sh got %0h/%0h/%0h want 0", bus.SH_DIR, bus.SH_AMT, bus.SH_D_IN); end
        RST_N = 1'b1;
        set_req(0, 1, 0, 5'd1, 32'h3);
        set_req(1, 1, 0, 5'd2, 32'h3);
        #1;
        nvec++; if (bus.REQ0_READY !== 1'b1 || bus.REQ1_READY !== 1'b0) begin nerr++; $display("FAIL midrst_tie got %0h%0h want 10", bus.REQ0_READY, bus.REQ1_READY); end
        @(negedge CLK);
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);
        @(negedge CLK);
        nvec++; if (bus.RES_DATA !== 32'h6 || bus.RES_ID !== 1'b0) begin nerr++; $display("FAIL midrst_res2 got %0h id%0h want 6 id0", bus.RES_DATA, bus.RES_ID); end
        @(negedge CLK);
        exp_cnt = 1; exp_last = 1'b0;
    endtask

    task automatic test_wrap();
        int seq [5] = '{1, 2, 3, 0, 1};
        do_reset();
        RST_N = 1'b1;
        bus.RES_READY = 1'b1;
        for (int k = 0; k < 5; k++) begin
            set_req(0, 1, 0, 5'(k), $urandom);
            @(negedge CLK);
            set_req(0, 0, 0, 0, 0);
            @(negedge CLK);
            @(negedge CLK);
            nvec++; if (bus.OP_CNT !== 2'(seq[k])) begin nerr++; $display("FAIL wrap%0d got %0d want %0d", k, bus.OP_CNT, seq[k]); end
        end
        exp_cnt = 1; exp_last = 1'b0;
    endtask

    task automatic test_random();
        logic        v [2];
        logic        dr [2];
        logic [4:0]  am [2];
        logic [31:0] dt [2];
        logic        eid;
        logic [31:0] want;
        int          r, dly;
        bus.RES_READY = 1'b0;
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(1, 3);
            v[0] = (r & 1) != 0; v[1] = (r & 2) != 0;
            for (int i = 0; i < 2; i++) begin
                dr[i] = 1'($urandom); am[i] = 5'($urandom); dt[i] = $urandom;
                if ($urandom_range(0, 3) == 0) am[i] = 5'($urandom_range(0, 1) * 31);
            end
            set_req(0, v[0], dr[0], am[0], dt[0]);
            set_req(1, v[1], dr[1], am[1], dt[1]);
            eid = (v[0] && v[1]) ? !exp_last : v[1];
            #1;
            nvec++; if (bus.REQ0_READY !== !eid || bus.REQ1_READY !== eid) begin nerr++; $display("FAIL rnd%0d_ready got %0h%0h want id%0h", n, bus.REQ0_READY, bus.REQ1_READY, eid); end
            @(negedge CLK);
            exp_last = eid;
            nvec++; if (bus.SH_DIR !== dr[eid] || bus.SH_AMT !== am[eid] || bus.SH_D_IN !== dt[eid] || bus.BUSY !== 1'b1) begin nerr++; $display("FAIL rnd%0d_sh got %0h/%0h/%0h want %0h/%0h/%0h", n, bus.SH_DIR, bus.SH_AMT, bus.SH_D_IN, dr[eid], am[eid], dt[eid]); end
            set_req(0, 0, 0, 0, 0);
            set_req(1, 0, 0, 0, 0);
            @(negedge CLK);
            want = ref_shift(dr[eid], am[eid], dt[eid]);
            nvec++; if (bus.RES_VALID !== 1'b1 || bus.RES_ID !== eid || bus.RES_DATA !== want) begin nerr++; $display("FAIL rnd%0d_res got v%0h id%0h %0h want v1 id%0h %0h", n, bus.RES_VALID, bus.RES_ID, bus.RES_DATA, eid, want); end
            dly = $urandom_range(0, 3);
            for (int c = 0; c < dly; c++) begin
                @(negedge CLK);
                nvec++; if (bus.RES_VALID !== 1'b1 || bus.RES_DATA !== want) begin nerr++; $display("FAIL rnd%0d_hold got v%0h %0h want v1 %0h", n, bus.RES_VALID, bus.RES_DATA, want); end
            end
            bus.RES_READY = 1'b1;
            @(negedge CLK);
            bus.RES_READY = 1'b0;
            exp_cnt = (exp_cnt + 1) % 4;
            nvec++; if (bus.RES_VALID !== 1'b0 || bus.OP_CNT !== 2'(exp_cnt)) begin nerr++; $display("FAIL rnd%0d_done got v%0h cnt%0d want 0/%0d", n, bus.RES_VALID, bus.OP_CNT, exp_cnt); end
        end
    endtask

    initial begin
        RST_N = 1'b0;
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);
        bus.RES_READY = 1'b0;
        test_reset();
        test_single();
        test_asr();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
